inc_scheduler: RTL and testbench
================================

INC_SCHEDULER -- requirements
Module: inc_scheduler

Interface
REQ-001 Parameter DIGITS, default 6: number of digit trigger requesters.
REQ-002 Parameter SETTLE, default 9: idle cycles between inc_clk pulse and ref_clk pulse.
REQ-003 Parameter HOLDOFF, default 10000: debounce block cycles after ref_clk before the next grant.
REQ-004 Parameter CNT_WIDTH, default 14: wait-counter width, SHALL hold max(SETTLE, HOLDOFF).
REQ-005 Port: clk  in  1  single clock; all state changes on posedge clk.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: trigger  in  DIGITS  per-digit requests, already synchronous to clk.
REQ-008 Port: inc_clk  out  1  one-cycle increment strobe for the granted digit.
REQ-009 Port: ref_clk  out  1  one-cycle display refresh strobe.
REQ-010 Port: digit_sel  out  DIGITS  one-hot granted digit, zero when no service is in progress.
REQ-011 Port: pending  out  DIGITS  captured, not-yet-served requests.
REQ-012 Port: busy  out  1  high in every state except IDLE.

Function
REQ-013 Rising-edge detection SHALL use trigger & ~trigger_q, with trigger_q registering trigger every cycle.
REQ-014 A detected edge SHALL set the matching pending bit in every state; a bit already set absorbs further edges.
REQ-015 FSM states SHALL be IDLE, INC, SETTLE, REFRESH and HOLD.
REQ-016 IDLE with pending != 0: next state INC; granted index g latched; pending[g] cleared.
REQ-017 Selection SHALL be round-robin: first set pending bit searching upward from last_grant+1, wrapping modulo DIGITS.
REQ-018 INC, exactly 1 cycle: inc_clk=1, digit_sel=onehot(g); next state SETTLE, or REFRESH if SETTLE=0.
REQ-019 SETTLE, exactly SETTLE cycles: inc_clk=0, digit_sel held; then REFRESH.
REQ-020 REFRESH, exactly 1 cycle: ref_clk=1, digit_sel held, last_grant<=g; next state HOLD, or IDLE if HOLDOFF=0.
REQ-021 HOLD, exactly HOLDOFF cycles: digit_sel=0; then IDLE.
REQ-022 Timing: inc_clk in cycle t, ref_clk in cycle t+SETTLE+1, earliest next inc_clk in cycle t+SETTLE+HOLDOFF+3.
REQ-023 An edge on digit g in the same cycle its bit is cleared SHALL win: pending[g] stays set.
REQ-024 inc_clk and ref_clk SHALL never be high together; each SHALL be exactly one cycle wide.
REQ-025 All outputs SHALL be driven from registers, with no combinational path from trigger.

Reset
REQ-026 Reset SHALL force state IDLE; inc_clk, ref_clk, digit_sel, pending, busy and the counter to 0.
REQ-027 Reset SHALL force last_grant to DIGITS-1, so the first search starts at digit 0.
REQ-028 Reset SHALL force trigger_q to all ones, so triggers held through reset generate no request.
REQ-029 Reset asserted mid-operation SHALL abort service immediately, with no partial strobe after deassertion.

Structure
REQ-030 A shared package SHALL hold the FSM state encodings (3-bit localparams) and the default SETTLE/HOLDOFF constants.
REQ-031 Round-robin selection SHALL live in one combinational sub-module rr_picker (inputs: req, last; outputs: grant index, valid).

Verification
(bench parameters: DIGITS=6, SETTLE=9, HOLDOFF=20)
REQ-032 Single request: trigger[2] rises -> one inc_clk with digit_sel=000100; ref_clk exactly 10 cycles later; busy low 21 cycles after ref_clk.
REQ-033 Simultaneous requests: trigger 000000->101001 in one cycle -> services in order 0, 3, 5; consecutive inc_clk pulses exactly 32 cycles apart.
REQ-034 Fairness/wrap: last_grant=4, pending=110001 -> next grants in order 5, 0, 4.
REQ-035 Re-trigger: trigger[1] re-rises in the same cycle its pending bit clears -> digit 1 served a second time.
REQ-036 Coalescing: trigger[3] toggled 3 times during one service -> only one extra service of digit 3.
REQ-037 Reset: reset pulsed during SETTLE while trigger=000010 held -> all outputs 0, no inc_clk after release until a new rising edge.

Source files
------------

// File: rtl/inc_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inc_scheduler_pkg
//  Description : Shared definitions for the increment scheduler: FSM state
//                encodings, default timing constants and a width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package inc_scheduler_pkg;

    // FSM state encodings (3-bit)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INC     = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_REFRESH = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    // Default parameter values
    localparam int DEFAULT_DIGITS    = 6;
    localparam int DEFAULT_SETTLE    = 9;
    localparam int DEFAULT_HOLDOFF   = 10000;
    localparam int DEFAULT_CNT_WIDTH = 14;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_INC     = ST_INC,
        S_SETTLE  = ST_SETTLE,
        S_REFRESH = ST_REFRESH,
        S_HOLD    = ST_HOLD
    } state_t;

    // Width of a digit index; never less than one bit so a single-digit
    // build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inc_scheduler_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Returns the first set
//                request bit found searching upward from last+1, wrapping
//                modulo DIGITS.
//  Ports       : req   in  DIGITS  request vector
//                last  in  IDX_W   index granted most recently
//                grant out IDX_W   selected index (0 when valid is low)
//                valid out 1       at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int DIGITS = 6,
    parameter int IDX_W  = 3
) (
    input  logic [DIGITS-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  grant,
    output logic              valid
);

    int               w_idx;
    logic [IDX_W-1:0] w_idx_v;

    // Walk the offsets from farthest to nearest so that the nearest set bit
    // after 'last' is the final (winning) assignment.
    always_comb begin
        grant   = '0;
        valid   = |req;
        w_idx   = 0;
        w_idx_v = '0;
        for (int off = DIGITS; off >= 1; off--) begin
            w_idx   = (int'(last) + off) % DIGITS;
            w_idx_v = IDX_W'(w_idx);
            if (req[w_idx_v]) begin
                grant = w_idx_v;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : inc_scheduler
//  Description : Serialises per-digit increment requests. Each serviced digit
//                gets a one-cycle inc_clk strobe, a SETTLE-cycle quiet gap, a
//                one-cycle ref_clk strobe and then a HOLDOFF-cycle debounce
//                block before the next grant. Requests are captured on rising
//                edges and served round-robin.
//  Ports       : clk       in  1       clock, rising edge
//                reset     in  1       asynchronous, active-high reset
//                trigger   in  DIGITS  per-digit requests (clk-synchronous)
//                inc_clk   out 1       increment strobe for granted digit
//                ref_clk   out 1       display refresh strobe
//                digit_sel out DIGITS  one-hot granted digit, 0 when idle/hold
//                pending   out DIGITS  captured, not-yet-served requests
//                busy      out 1       high in every state except IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module inc_scheduler
    import inc_scheduler_pkg::*;
#(
    parameter int DIGITS    = DEFAULT_DIGITS,
    parameter int SETTLE    = DEFAULT_SETTLE,
    parameter int HOLDOFF   = DEFAULT_HOLDOFF,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIGITS-1:0] trigger,
    output logic              inc_clk,
    output logic              ref_clk,
    output logic [DIGITS-1:0] digit_sel,
    output logic [DIGITS-1:0] pending,
    output logic              busy
);

    localparam int IDX_W = idx_width(DIGITS);

    // Counter reload values: the wait states exit when the counter reads 0,
    // so loading N-1 yields exactly N cycles in the state.
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD  =
        (SETTLE > 0) ? CNT_WIDTH'(SETTLE - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] HOLDOFF_LOAD =
        (HOLDOFF > 0) ? CNT_WIDTH'(HOLDOFF - 1) : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,      state_d;
    logic [CNT_WIDTH-1:0]  cnt_q,        cnt_d;
    logic [IDX_W-1:0]      grant_q,      grant_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [DIGITS-1:0]     trigger_q,    trigger_d;
    logic [DIGITS-1:0]     pending_q,    pending_d;
    logic                  inc_clk_q,    inc_clk_d;
    logic                  ref_clk_q,    ref_clk_d;
    logic [DIGITS-1:0]     digit_sel_q,  digit_sel_d;
    logic                  busy_q,       busy_d;

    logic [DIGITS-1:0]     w_rise;
    logic [DIGITS-1:0]     w_clear;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;

    function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Round-robin selection over the captured requests
    // ------------------------------------------------------------------
    rr_picker #(
        .DIGITS (DIGITS),
        .IDX_W  (IDX_W)
    ) u_rr_picker (
        .req   (pending_q),
        .last  (last_grant_q),
        .grant (w_pick_idx),
        .valid (w_pick_valid)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_rise       = trigger & ~trigger_q;
        w_clear      = '0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        trigger_d    = trigger;

        case (state_q)
            S_IDLE: begin
                if (w_pick_valid) begin
                    state_d = S_INC;
                    grant_d = w_pick_idx;
                    w_clear = onehot(w_pick_idx);
                end
            end
            S_INC: begin
                if (SETTLE == 0) begin
                    state_d = S_REFRESH;
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_REFRESH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REFRESH: begin
                last_grant_d = grant_q;
                if (HOLDOFF == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = HOLDOFF_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new edge is OR-ed in after the clear, so an edge arriving in the
        // same cycle its bit is granted keeps the request alive.
        pending_d = (pending_q & ~w_clear) | w_rise;

        // Outputs are decoded from the next state and registered, so each
        // output flop is aligned with the state it describes.
        inc_clk_d   = (state_d == S_INC);
        ref_clk_d   = (state_d == S_REFRESH);
        busy_d      = (state_d != S_IDLE);
        digit_sel_d = ((state_d == S_INC) || (state_d == S_SETTLE) ||
                       (state_d == S_REFRESH)) ? onehot(grant_d) : '0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(DIGITS - 1);
            // All ones: a trigger already high during reset is not an edge.
            trigger_q    <= '1;
            pending_q    <= '0;
            inc_clk_q    <= 1'b0;
            ref_clk_q    <= 1'b0;
            digit_sel_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            trigger_q    <= trigger_d;
            pending_q    <= pending_d;
            inc_clk_q    <= inc_clk_d;
            ref_clk_q    <= ref_clk_d;
            digit_sel_q  <= digit_sel_d;
            busy_q       <= busy_d;
        end
    end

    assign inc_clk   = inc_clk_q;
    assign ref_clk   = ref_clk_q;
    assign digit_sel = digit_sel_q;
    assign pending   = pending_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_inc_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_inc_scheduler
//  Description : Self-checking bench for inc_scheduler (DIGITS=6, SETTLE=9,
//                HOLDOFF=20). Expected grants are queued when stimulus is
//                driven and popped by a monitor on every inc_clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inc_scheduler;

    localparam int DIGITS    = 6;
    localparam int SETTLE    = 9;
    localparam int HOLDOFF   = 20;
    localparam int CNT_WIDTH = 14;
    localparam int PERIOD    = SETTLE + HOLDOFF + 3;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [DIGITS-1:0] trigger = '0;
    logic              inc_clk;
    logic              ref_clk;
    logic [DIGITS-1:0] digit_sel;
    logic [DIGITS-1:0] pending;
    logic              busy;

    inc_scheduler #(
        .DIGITS    (DIGITS),
        .SETTLE    (SETTLE),
        .HOLDOFF   (HOLDOFF),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .inc_clk   (inc_clk),
        .ref_clk   (ref_clk),
        .digit_sel (digit_sel),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int inc_times[$];
    int n_inc = 0;
    int n_ref = 0;
    int exp_ref_cyc = -1;
    logic [DIGITS-1:0] exp_ref_sel = '0;
    int last_ref_cyc = 0;
    int idle_cyc = 0;
    int mon_e;

    // Vector table: a rising trigger pattern from all-zero and the service
    // order it must produce after reset. order[k] is the k-th grant, so the
    // concatenations below list the last grant first.
    typedef struct packed {
        logic [DIGITS-1:0] trig;
        logic [3:0]        n;
        logic [5:0][2:0]   order;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [DIGITS-1:0] oh(input int i);
        logic [DIGITS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) tick(1);
    endtask

    // Monitor: every inc_clk consumes one expected grant and arms the ref_clk
    // check SETTLE+1 cycles later.
    always @(negedge clk) begin
        if (!reset) begin
            if (inc_clk && ref_clk) begin
                chk("strobes_overlap", 32'(inc_clk & ref_clk), 32'd0);
            end
            if (inc_clk) begin
                n_inc++;
                inc_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_inc: digit_sel=%b, expected no service", digit_sel);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inc_digit_sel", 32'(digit_sel), 32'(oh(mon_e)));
                end
                exp_ref_cyc = cyc + SETTLE + 1;
                exp_ref_sel = digit_sel;
            end
            if (ref_clk) begin
                n_ref++;
                last_ref_cyc = cyc;
                chk("ref_cycle", cyc, exp_ref_cyc);
                chk("ref_digit_sel", 32'(digit_sel), 32'(exp_ref_sel));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_inc_clk",   32'(inc_clk),   32'd0);
        chk("rst_ref_clk",   32'(ref_clk),   32'd0);
        chk("rst_digit_sel", 32'(digit_sel), 32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        n_inc = 0;
        n_ref = 0;
        inc_times.delete();
    endtask

    // Waits until every queued service has started and the block is idle.
    task automatic wait_idle(input string name, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) begin
                done     = 1'b1;
                idle_cyc = cyc;
            end
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: %0d services outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_inc(input string name, output int t);
        bit got;
        got = 1'b0;
        t   = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            #1;
            if (inc_clk) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s_no_inc: inc_clk=0, expected a pulse", name);
        end
    endtask

    initial begin
        int t;

        vecs[0] = '{trig: 6'b000100, n: 4'd1, order: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2}};
        vecs[1] = '{trig: 6'b101001, n: 4'd3, order: {3'd0, 3'd0, 3'd0, 3'd5, 3'd3, 3'd0}};
        vecs[2] = '{trig: 6'b000001, n: 4'd1, order: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        vecs[3] = '{trig: 6'b100000, n: 4'd1, order: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5}};
        vecs[4] = '{trig: 6'b111111, n: 4'd6, order: {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        vecs[5] = '{trig: 6'b010010, n: 4'd2, order: {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1}};

        // Power-on reset state
        tick(1);
        @(negedge clk);
        chk("por_inc_clk",   32'(inc_clk),   32'd0);
        chk("por_ref_clk",   32'(ref_clk),   32'd0);
        chk("por_digit_sel", 32'(digit_sel), 32'd0);
        chk("por_pending",   32'(pending),   32'd0);
        chk("por_busy",      32'(busy),      32'd0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 6; i++) begin
            trigger = '0;
            do_reset();
            trigger = vecs[i].trig;
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                exp_q.push_back(int'(vecs[i].order[k]));
            end
            wait_idle($sformatf("v%0d", i), 400);
            chk($sformatf("v%0d_inc_count", i), n_inc, int'(vecs[i].n));
            chk($sformatf("v%0d_ref_count", i), n_ref, int'(vecs[i].n));
            for (int k = 1; k < inc_times.size(); k++) begin
                chk($sformatf("v%0d_inc_spacing", i), inc_times[k] - inc_times[k-1], PERIOD);
            end
            chk($sformatf("v%0d_pending_end", i), 32'(pending), 32'd0);
            trigger = '0;
            tick(2);
        end

        // ---------------- single request timing detail ----------------
        trigger = '0;
        do_reset();
        trigger = 6'b000100;
        exp_q.push_back(2);
        wait_inc("single", t);
        goto_cycle(t + 5);
        @(negedge clk);
        chk("settle_digit_sel", 32'(digit_sel), 32'h04);
        chk("settle_inc_clk",   32'(inc_clk),   32'd0);
        chk("settle_busy",      32'(busy),      32'd1);
        goto_cycle(t + 15);
        @(negedge clk);
        chk("hold_digit_sel",   32'(digit_sel), 32'd0);
        chk("hold_busy",        32'(busy),      32'd1);
        wait_idle("single", 200);
        chk("busy_low_after_ref", idle_cyc - last_ref_cyc, HOLDOFF + 1);
        trigger = '0;
        tick(2);

        // ---------------- fairness / wrap ----------------
        do_reset();
        trigger = 6'b010000;
        exp_q.push_back(4);
        wait_inc("fair", t);
        tick(1);
        trigger = 6'b000000;
        tick(1);
        trigger = 6'b110001;
        exp_q.push_back(5);
        exp_q.push_back(0);
        exp_q.push_back(4);
        goto_cycle(t + 4);
        @(negedge clk);
        chk("fair_pending", 32'(pending), 32'h31);
        wait_idle("fair", 400);
        chk("fair_inc_count", n_inc, 4);
        trigger = '0;
        tick(2);

        // ---------------- re-trigger on the clearing cycle ----------------
        do_reset();
        trigger = 6'b000001;
        exp_q.push_back(0);
        tick(1);
        trigger = 6'b000011;
        exp_q.push_back(1);
        wait_inc("retrig", t);
        goto_cycle(t + PERIOD - 2);
        trigger = 6'b000001;
        goto_cycle(t + PERIOD - 1);
        trigger = 6'b000011;
        exp_q.push_back(1);
        @(negedge clk);
        chk("retrig_idle_cycle", 32'(busy), 32'd0);
        goto_cycle(t + PERIOD);
        @(negedge clk);
        #1;
        chk("retrig_inc_on_time", 32'(inc_clk), 32'd1);
        chk("retrig_pending_kept", 32'(pending), 32'h02);
        wait_idle("retrig", 400);
        chk("retrig_inc_count", n_inc, 3);
        trigger = '0;
        tick(2);

        // ---------------- coalescing ----------------
        do_reset();
        trigger = 6'b000001;
        exp_q.push_back(0);
        wait_inc("coal", t);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            trigger = 6'b001001;
            tick(1);
            trigger = 6'b000001;
        end
        exp_q.push_back(3);
        tick(1);
        chk("coal_pending", 32'(pending), 32'h08);
        wait_idle("coal", 400);
        chk("coal_inc_count", n_inc, 2);
        trigger = '0;
        tick(2);

        // ---------------- reset during SETTLE ----------------
        do_reset();
        trigger = 6'b000010;
        exp_q.push_back(1);
        wait_inc("mrst", t);
        goto_cycle(t + 4);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_inc_clk",   32'(inc_clk),   32'd0);
        chk("mrst_ref_clk",   32'(ref_clk),   32'd0);
        chk("mrst_digit_sel", 32'(digit_sel), 32'd0);
        chk("mrst_pending",   32'(pending),   32'd0);
        chk("mrst_busy",      32'(busy),      32'd0);
        tick(2);
        reset = 1'b0;
        n_inc = 0;
        n_ref = 0;
        tick(60);
        chk("mrst_no_inc",      n_inc, 0);
        chk("mrst_no_ref",      n_ref, 0);
        chk("mrst_idle_busy",   32'(busy),    32'd0);
        chk("mrst_idle_pend",   32'(pending), 32'd0);
        trigger = '0;
        tick(1);
        trigger = 6'b000010;
        exp_q.push_back(1);
        wait_idle("mrst_new_edge", 200);
        chk("mrst_new_inc_count", n_inc, 1);
        trigger = '0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
